// File: rtl/yin_pkg.sv
// Shared definitions for the YIN lag scheduler and its threshold comparator.
package yin_pkg;

  localparam int unsigned TAU_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    EVAL,
    DONE
  } state_e;

  function automatic int unsigned sum_width(input int unsigned data_w);
    return data_w + TAU_W;
  endfunction

  function automatic int unsigned cmp_width(input int unsigned data_w, input int unsigned frac_bits);
    return data_w + TAU_W + frac_bits + 2;
  endfunction

  localparam int unsigned SUM_W = sum_width(64);
  localparam int unsigned CMP_W = cmp_width(64, 8);

endpackage

// File: rtl/yin_threshold_cmp.sv
// Divider-free CMNDF threshold test: d*tau/S < th  <=>  (d*tau << F) < th*S.
module yin_threshold_cmp
  import yin_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned TH_FRAC_BITS = 8
) (
  input  logic [DATA_W-1:0]       d_i,
  input  logic [TAU_W-1:0]        tau_i,
  input  logic [DATA_W+TAU_W-1:0] sum_i,
  input  logic [TH_FRAC_BITS-1:0] threshold_i,
  output logic                    pass_o
);

  localparam int unsigned CW = cmp_width(DATA_W, TH_FRAC_BITS);

  logic [CW-1:0] lhs;
  logic [CW-1:0] rhs;

  always_comb begin
    lhs    = (CW'(d_i) * CW'(tau_i)) << TH_FRAC_BITS;
    rhs    = CW'(threshold_i) * CW'(sum_i);
    pass_o = (sum_i != '0) && (lhs < rhs);
  end

endmodule

// File: rtl/yin_tau_scheduler.sv
// Steps the shared difference engine over TAU_MIN..MAX_TAU and stops at the
// first local minimum of d(tau) whose normalised value falls below threshold.
module yin_tau_scheduler
  import yin_pkg::*;
#(
  parameter int unsigned WINDOW_SIZE_BITS        = 8,
  parameter int unsigned INTERMEDIATE_DATA_WIDTH = 64,
  parameter int unsigned TAU_MIN                 = 2,
  parameter int unsigned MAX_TAU                 = 40,
  parameter int unsigned TH_FRAC_BITS            = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [TH_FRAC_BITS-1:0]            threshold,
  output logic                               busy,
  output logic                               done,
  output logic                               found,
  output logic [TAU_W-1:0]                   tau_out,
  output logic [INTERMEDIATE_DATA_WIDTH-1:0] d_out,
  output logic                               eng_reset,
  output logic [TAU_W-1:0]                   eng_tau,
  input  logic                               eng_ready,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0] eng_accumulator
);

  localparam int unsigned DW = INTERMEDIATE_DATA_WIDTH;
  localparam int unsigned SW = sum_width(DW);

  state_e                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    found_q;
  logic [TAU_W-1:0]        tau_out_q;
  logic [DW-1:0]           d_out_q;
  logic                    eng_reset_q;
  logic [TAU_W-1:0]        eng_tau_q;
  logic [SW-1:0]           sum_q;
  logic [SW-1:0]           sum_d;
  logic [TH_FRAC_BITS-1:0] th_q;
  logic                    below_q;
  logic [DW-1:0]           prev_d_q;
  logic [DW-1:0]           d_q;
  logic                    pass;
  logic                    at_max;

  assign sum_d  = sum_q + SW'(eng_accumulator);
  assign at_max = (eng_tau_q == TAU_W'(MAX_TAU));

  yin_threshold_cmp #(
    .DATA_W       (DW),
    .TH_FRAC_BITS (TH_FRAC_BITS)
  ) u_cmp (
    .d_i         (d_q),
    .tau_i       (eng_tau_q),
    .sum_i       (sum_q),
    .threshold_i (th_q),
    .pass_o      (pass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      tau_out_q   <= '0;
      d_out_q     <= '0;
      eng_reset_q <= 1'b1;
      eng_tau_q   <= '0;
      sum_q       <= '0;
      th_q        <= '0;
      below_q     <= 1'b0;
      prev_d_q    <= '0;
      d_q         <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            th_q        <= threshold;
            eng_tau_q   <= TAU_W'(TAU_MIN);
            sum_q       <= '0;
            below_q     <= 1'b0;
            prev_d_q    <= '0;
            found_q     <= 1'b0;
            tau_out_q   <= '0;
            d_out_q     <= '0;
            busy_q      <= 1'b1;
            eng_reset_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          eng_reset_q <= 1'b0;
          state_q     <= RUN;
        end
        RUN: begin
          if (eng_ready) begin
            d_q     <= eng_accumulator;
            sum_q   <= sum_d;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          // The rising-edge test uses the flag from earlier lags only; the
          // current lag's pass result feeds the range-end decision directly.
          if (below_q && (d_q >= prev_d_q)) begin
            found_q     <= 1'b1;
            tau_out_q   <= eng_tau_q - TAU_W'(1);
            d_out_q     <= prev_d_q;
            done_q      <= 1'b1;
            eng_reset_q <= 1'b1;
            state_q     <= DONE;
          end else if (at_max) begin
            found_q     <= below_q | pass;
            tau_out_q   <= (below_q | pass) ? eng_tau_q : '0;
            d_out_q     <= (below_q | pass) ? d_q : '0;
            below_q     <= below_q | pass;
            done_q      <= 1'b1;
            eng_reset_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            below_q     <= below_q | pass;
            prev_d_q    <= d_q;
            eng_tau_q   <= eng_tau_q + TAU_W'(1);
            eng_reset_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign tau_out   = tau_out_q;
  assign d_out     = d_out_q;
  assign eng_reset = eng_reset_q | reset;
  assign eng_tau   = eng_tau_q;

endmodule
